game_sequencer: RTL and testbench



---
 rtl/game_sequencer_if.sv | 47 ++++
 rtl/game_sequencer.sv | 122 ++++++++++++
 tb/tb_game_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Bundle between the game sequencer and its neighbours (buttons, ball, display).
// master drives tick/buttons/ball events and reads state; slave is the sequencer.
interface game_sequencer_if #(
  parameter int LIVES   = 5,
  parameter int LIVES_W = 3,
  parameter int CNT_W   = 5
);
  logic               tick;
  logic               start_press;
  logic               pause_press;
  logic               ball_lost;
  logic               bricks_clear;
  logic [2:0]         state;
  logic               run_en;
  logic               ball_serve;
  logic [LIVES_W-1:0] lives;
  logic [LIVES-1:0]   lives_bar;
  logic [CNT_W-1:0]   serve_cnt;

  modport master (
    output tick,
    output start_press,
    output pause_press,
    output ball_lost,
    output bricks_clear,
    input  state,
    input  run_en,
    input  ball_serve,
    input  lives,
    input  lives_bar,
    input  serve_cnt
  );

  modport slave (
    input  tick,
    input  start_press,
    input  pause_press,
    input  ball_lost,
    input  bricks_clear,
    output state,
    output run_en,
    output ball_serve,
    output lives,
    output lives_bar,
    output serve_cnt
  );
endinterface

// File: rtl/game_sequencer.sv
// Brick-breaker play flow: MENU/SERVE/PLAY/WIN/LOSE, lives and serve countdown.
// Ports: clk, rst (async, active-high), bus (game_sequencer_if.slave).
// Optional pause state enabled by defining GAME_SEQ_PAUSE_EN.
module game_sequencer #(
  parameter int LIVES       = 5,
  parameter int LIVES_W     = 3,
  parameter int SERVE_TICKS = 20,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    WIN   = 3'd1,
    LOSE  = 3'd2,
    SERVE = 3'd3,
    PLAY  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  localparam logic [LIVES_W-1:0] LIVES_INIT =
    LIVES_W'(LIVES);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SERVE_TICKS - 1);
  localparam logic [LIVES_W-1:0] ONE_LIFE =
    LIVES_W'(1);

  state_t             st_q;
  logic [LIVES_W-1:0] lives_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               serve_q;
  logic [LIVES-1:0]   bar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= MENU;
      lives_q <= '0;
      cnt_q   <= '0;
      serve_q <= 1'b0;
    end else begin
      serve_q <= 1'b0;
      unique case (st_q)
        MENU: begin
          if (bus.start_press) begin
            st_q    <= SERVE;
            lives_q <= LIVES_INIT;
            cnt_q   <= CNT_INIT;
          end
        end
        SERVE: begin
          if (bus.tick) begin
            if (cnt_q == '0) begin
              st_q    <= PLAY;
              serve_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        PLAY: begin
          if (bus.bricks_clear) begin
            st_q <= WIN;
          end else if (bus.ball_lost) begin
            if (lives_q > ONE_LIFE) begin
              st_q    <= SERVE;
              lives_q <= lives_q - ONE_LIFE;
              cnt_q   <= CNT_INIT;
            end else begin
              st_q    <= LOSE;
              lives_q <= '0;
            end
          end
`ifdef GAME_SEQ_PAUSE_EN
          else if (bus.pause_press) begin
            st_q <= PAUSE;
          end
`endif
        end
        WIN, LOSE: begin
          if (bus.start_press) begin
            st_q <= MENU;
          end
        end
`ifdef GAME_SEQ_PAUSE_EN
        PAUSE: begin
          if (bus.pause_press) begin
            st_q <= PLAY;
          end
        end
`endif
        default: begin
          // Covers encodings 6/7 and PAUSE when the pause feature is off.
          st_q <= MENU;
        end
      endcase
    end
  end

`ifndef GAME_SEQ_PAUSE_EN
  logic unused_pause;
  assign unused_pause = bus.pause_press;
`endif

  // Thermometer: bit i lit while more than i lives remain.
  always_comb begin
    bar = '0;
    for (int i = 0; i < LIVES; i++) begin
      bar[i] = (int'(lives_q) > i);
    end
  end

  assign bus.state      = st_q;
  assign bus.run_en     = (st_q == PLAY);
  assign bus.ball_serve = serve_q;
  assign bus.lives      = lives_q;
  assign bus.lives_bar  = bar;
  assign bus.serve_cnt  = cnt_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized check of game_sequencer against a rule-level game model.
// Build with or without GAME_SEQ_PAUSE_EN; the model follows the same macro.
module tb_game_sequencer;

  localparam int LIVES       = 5;
  localparam int LIVES_W     = 3;
  localparam int SERVE_TICKS = 20;
  localparam int CNT_W       = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  game_sequencer_if #(
    .LIVES(LIVES), .LIVES_W(LIVES_W), .CNT_W(CNT_W)
  ) bus ();

  game_sequencer #(
    .LIVES(LIVES), .LIVES_W(LIVES_W),
    .SERVE_TICKS(SERVE_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // game model: mode names as plain numbers from the state map
  int m_mode;
  int m_lives;
  int m_left;
  bit m_launch;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_lives  = 0;
    m_left   = 0;
    m_launch = 0;
  endtask

  task automatic model_step(bit t, bit s, bit p, bit l, bit c);
    m_launch = 0;
    case (m_mode)
      0: if (s) begin
        m_mode  = 3;
        m_lives = LIVES;
        m_left  = SERVE_TICKS - 1;
      end
      3: if (t) begin
        if (m_left == 0) begin
          m_mode   = 4;
          m_launch = 1;
        end else m_left = m_left - 1;
      end
      4: begin
        if (c) m_mode = 1;
        else if (l) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_mode = 2;
          else begin
            m_mode = 3;
            m_left = SERVE_TICKS - 1;
          end
        end
`ifdef GAME_SEQ_PAUSE_EN
        else if (p) m_mode = 5;
`endif
      end
      1, 2: if (s) m_mode = 0;
      5: if (p) m_mode = 4;
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_all(string tag);
    chk({tag, ".state"}, 32'(bus.state), m_mode);
    chk({tag, ".run_en"}, 32'(bus.run_en), 32'(m_mode == 4));
    chk({tag, ".serve"}, 32'(bus.ball_serve), 32'(m_launch));
    chk({tag, ".lives"}, 32'(bus.lives), m_lives);
    chk({tag, ".bar"}, 32'(bus.lives_bar), (1 << m_lives) - 1);
    chk({tag, ".cnt"}, 32'(bus.serve_cnt), m_left);
  endtask

  task automatic cyc(string tag, bit t, bit s, bit p,
                     bit l, bit c);
    @(negedge clk);
    bus.tick         = t;
    bus.start_press  = s;
    bus.pause_press  = p;
    bus.ball_lost    = l;
    bus.bricks_clear = c;
    model_step(t, s, p, l, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(string tag);
    cyc(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic serve_out(string tag);
    for (int i = 0; i < SERVE_TICKS; i++) begin
      cyc(tag, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic async_reset(string tag);
    @(negedge clk);
    bus.tick         = 0;
    bus.start_press  = 0;
    bus.pause_press  = 0;
    bus.ball_lost    = 0;
    bus.bricks_clear = 0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.tick         = 0;
    bus.start_press  = 0;
    bus.pause_press  = 0;
    bus.ball_lost    = 0;
    bus.bricks_clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    cyc("start", 0, 1, 0, 0, 0);
    chk("start_lives_bar", 32'(bus.lives_bar), 32'h1f);
    chk("start_cnt", 32'(bus.serve_cnt), 19);
    serve_out("serve1");
    chk("launch_pulse", 32'(bus.ball_serve), 1);
    idle("after_launch");
    chk("launch_once", 32'(bus.ball_serve), 0);

    cyc("lost1", 0, 0, 0, 1, 0);
    chk("lost1_bar", 32'(bus.lives_bar), 32'h0f);
    for (int i = 0; i < 6; i++)
      cyc("serve_lost", 1, 0, 0, 1, 0);
    chk("serve_lost_lives", 32'(bus.lives), 4);
    serve_out("serve2");

    for (int k = 0; k < 4; k++) begin
      cyc("lose_run", 0, 0, 0, 1, 0);
      if (k < 3) serve_out("lose_serve");
    end
    chk("lose_state", 32'(bus.state), 2);
    chk("lose_lives", 32'(bus.lives), 0);
    cyc("lose_start", 0, 1, 0, 0, 0);

    cyc("win_start", 0, 1, 0, 0, 0);
    serve_out("win_serve");
    cyc("win_both", 0, 0, 0, 1, 1);
    chk("win_state", 32'(bus.state), 1);
    chk("win_lives", 32'(bus.lives), 5);
    cyc("win_exit", 0, 1, 0, 0, 0);

    cyc("rst_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      cyc("rst_tick", 1, 0, 0, 0, 0);
    chk("rst_pre_cnt", 32'(bus.serve_cnt), 7);
    async_reset("rst_mid");

    cyc("pz_start", 0, 1, 0, 0, 0);
    serve_out("pz_serve");
    cyc("pz_on", 0, 0, 1, 0, 0);
    idle("pz_idle");
`ifdef GAME_SEQ_PAUSE_EN
    cyc("pz_lost", 0, 0, 0, 1, 0);
    cyc("pz_clear", 0, 0, 0, 0, 1);
`endif
    cyc("pz_off", 0, 0, 1, 0, 0);
    chk("pz_state", 32'(bus.state), 4);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cyc("rnd",
            $urandom_range(0, 1) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 29) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
